// File: rtl/ddr2_wb_pkg.sv
// Shared state encodings and default geometry for the ddr2_wb write-posting buffer.
package ddr2_wb_pkg;

  localparam int unsigned DEF_AW  = 32;
  localparam int unsigned DEF_DW  = 32;
  localparam int unsigned ENTRY_W = DEF_AW + DEF_DW + DEF_DW / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WACK  = 2'd1,
    S_RWAIT = 2'd2,
    S_RACK  = 2'd3
  } s_state_e;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_WR   = 2'd1,
    M_RD   = 2'd2
  } m_state_e;

endpackage

// File: rtl/wb_sync_fifo.sv
// Single-clock FIFO with a combinational head and an occupancy count 0..DEPTH.
module wb_sync_fifo
  import ddr2_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = ENTRY_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ddr2_wb_wbuf.sv
// Write-posting buffer: acks CPU writes on enqueue, drains them in order to ddr2_wb,
// and forwards reads only once every earlier write has completed downstream.
module ddr2_wb_wbuf
  import ddr2_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DW    = DEF_DW
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            s_cyc_i,
  input  logic            s_stb_i,
  input  logic            s_we_i,
  input  logic [DW/8-1:0] s_sel_i,
  input  logic [AW-1:0]   s_adr_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [DW-1:0]   s_dat_o,
  output logic            s_ack_o,
  output logic            m_cyc_o,
  output logic            m_stb_o,
  output logic            m_we_o,
  output logic [DW/8-1:0] m_sel_o,
  output logic [AW-1:0]   m_adr_o,
  output logic [DW-1:0]   m_dat_o,
  input  logic [DW-1:0]   m_dat_i,
  input  logic            m_ack_i,
  output logic            wbuf_empty
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned EW = AW + SW + DW;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  s_state_e        s_state, s_state_n;
  m_state_e        m_state, m_state_n;
  logic            push_c, pop_c;
  logic [EW-1:0]   head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;
  logic            rd_req;
  logic [AW-1:0]   rd_adr, rd_adr_n;
  logic            s_ack_n;
  logic [DW-1:0]   s_dat_n;
  logic            m_cyc_n, m_stb_n, m_we_n;
  logic [SW-1:0]   m_sel_n;
  logic [AW-1:0]   m_adr_n;
  logic [DW-1:0]   m_dat_n;

  wb_sync_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push_c),
    .pop   (pop_c),
    .din   ({s_adr_i, s_sel_i, s_dat_i}),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_req     = (s_state == S_RWAIT);
  assign wbuf_empty = (fifo_count == '0) && ((m_state == M_IDLE) || (m_state == M_RD));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s_state <= S_IDLE;
      m_state <= M_IDLE;
      s_ack_o <= 1'b0;
      s_dat_o <= '0;
      rd_adr  <= '0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
    end else begin
      s_state <= s_state_n;
      m_state <= m_state_n;
      s_ack_o <= s_ack_n;
      s_dat_o <= s_dat_n;
      rd_adr  <= rd_adr_n;
      m_cyc_o <= m_cyc_n;
      m_stb_o <= m_stb_n;
      m_we_o  <= m_we_n;
      m_sel_o <= m_sel_n;
      m_adr_o <= m_adr_n;
      m_dat_o <= m_dat_n;
    end
  end

  // Upstream side: posts writes into the queue, parks reads until the master returns data.
  always_comb begin
    s_state_n = s_state;
    s_ack_n   = 1'b0;
    s_dat_n   = s_dat_o;
    rd_adr_n  = rd_adr;
    push_c    = 1'b0;
    case (s_state)
      S_IDLE: begin
        if (s_cyc_i && s_stb_i && s_we_i) begin
          if (!fifo_full) begin
            push_c    = 1'b1;
            s_ack_n   = 1'b1;
            s_state_n = S_WACK;
          end
        end else if (s_cyc_i && s_stb_i) begin
          rd_adr_n  = s_adr_i;
          s_state_n = S_RWAIT;
        end
      end
      S_WACK:  s_state_n = S_IDLE;
      S_RWAIT: begin
        if (m_ack_i && (m_state == M_RD)) begin
          s_dat_n   = m_dat_i;
          s_ack_n   = 1'b1;
          s_state_n = S_RACK;
        end
      end
      S_RACK:  s_state_n = S_IDLE;
      default: s_state_n = S_IDLE;
    endcase
  end

  // Downstream side: queued writes always win, so a read only issues on an empty queue.
  always_comb begin
    m_state_n = m_state;
    m_cyc_n   = m_cyc_o;
    m_stb_n   = m_stb_o;
    m_we_n    = m_we_o;
    m_sel_n   = m_sel_o;
    m_adr_n   = m_adr_o;
    m_dat_n   = m_dat_o;
    pop_c     = 1'b0;
    case (m_state)
      M_IDLE: begin
        if (!fifo_empty) begin
          m_cyc_n   = 1'b1;
          m_stb_n   = 1'b1;
          m_we_n    = 1'b1;
          m_adr_n   = head[EW-1 -: AW];
          m_sel_n   = head[DW+SW-1 -: SW];
          m_dat_n   = head[DW-1:0];
          m_state_n = M_WR;
        end else if (rd_req) begin
          m_cyc_n   = 1'b1;
          m_stb_n   = 1'b1;
          m_we_n    = 1'b0;
          m_sel_n   = '1;
          m_adr_n   = rd_adr;
          m_state_n = M_RD;
        end
      end
      M_WR: begin
        if (m_ack_i) begin
          pop_c     = 1'b1;
          m_cyc_n   = 1'b0;
          m_stb_n   = 1'b0;
          m_we_n    = 1'b0;
          m_state_n = M_IDLE;
        end
      end
      M_RD: begin
        if (m_ack_i) begin
          m_cyc_n   = 1'b0;
          m_stb_n   = 1'b0;
          m_state_n = M_IDLE;
        end
      end
      default: m_state_n = M_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddr2_wb_wbuf.sv
// Directed bench for ddr2_wb_wbuf against a ddr2_wb model that acks a fixed time after stb.
module tb_ddr2_wb_wbuf;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i = 1'b1;
  logic            s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
  logic [SW-1:0]   s_sel_i = '0;
  logic [AW-1:0]   s_adr_i = '0;
  logic [DW-1:0]   s_dat_i = '0;
  logic [DW-1:0]   s_dat_o;
  logic            s_ack_o;
  logic            m_cyc_o, m_stb_o, m_we_o;
  logic [SW-1:0]   m_sel_o;
  logic [AW-1:0]   m_adr_o;
  logic [DW-1:0]   m_dat_o;
  logic [DW-1:0]   m_dat_i;
  logic            m_ack_i;
  logic            wbuf_empty;

  int errors = 0;
  int checks = 0;
  int lat = 10;
  int cnt;
  int up_acks = 0;
  int dn_acks = 0;
  int order_viol = 0;
  int stb_cycles = 0;
  logic [AW+SW+DW-1:0] wr_log [$];
  logic [DW-1:0]       mem [logic [AW-1:0]];
  logic [SW-1:0]       last_rd_sel = '0;
  logic [AW-1:0]       last_rd_adr = '0;

  ddr2_wb_wbuf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .s_cyc_i    (s_cyc_i),
    .s_stb_i    (s_stb_i),
    .s_we_i     (s_we_i),
    .s_sel_i    (s_sel_i),
    .s_adr_i    (s_adr_i),
    .s_dat_i    (s_dat_i),
    .s_dat_o    (s_dat_o),
    .s_ack_o    (s_ack_o),
    .m_cyc_o    (m_cyc_o),
    .m_stb_o    (m_stb_o),
    .m_we_o     (m_we_o),
    .m_sel_o    (m_sel_o),
    .m_adr_o    (m_adr_o),
    .m_dat_o    (m_dat_o),
    .m_dat_i    (m_dat_i),
    .m_ack_i    (m_ack_i),
    .wbuf_empty (wbuf_empty)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ddr2_wb model: 1-cycle ack after stb has been high for lat cycles.
  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m_ack_i <= 1'b0;
      m_dat_i <= '0;
      cnt     <= 0;
    end else begin
      if (m_stb_o) stb_cycles <= stb_cycles + 1;
      if (m_stb_o && !m_we_o && (up_acks != dn_acks)) order_viol <= order_viol + 1;
      if (m_ack_i) begin
        m_ack_i <= 1'b0;
        cnt     <= 0;
      end else if (m_stb_o) begin
        if (cnt == lat - 1) begin
          m_ack_i <= 1'b1;
          if (m_we_o) begin
            wr_log.push_back({m_adr_o, m_sel_o, m_dat_o});
            mem[m_adr_o] = merge(mem.exists(m_adr_o) ? mem[m_adr_o] : '0, m_dat_o, m_sel_o);
            dn_acks <= dn_acks + 1;
          end else begin
            last_rd_sel <= m_sel_o;
            last_rd_adr <= m_adr_o;
            m_dat_i     <= mem.exists(m_adr_o) ? mem[m_adr_o] : '0;
          end
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
  endtask

  task automatic wb_write(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [SW-1:0] sel, output int l);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
    s_adr_i = adr; s_dat_i = dat; s_sel_i = sel;
    l = 0;
    do begin cyc1(); l++; end while (!s_ack_o && l < 200);
    chk("wr_ack", 96'(s_ack_o), 96'(1));
    up_acks++;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    cyc1();
  endtask

  task automatic wb_read(input logic [AW-1:0] adr, output logic [DW-1:0] dat);
    int l;
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b0;
    s_adr_i = adr; s_sel_i = 4'hF;
    l = 0;
    do begin cyc1(); l++; end while (!s_ack_o && l < 500);
    chk("rd_ack", 96'(s_ack_o), 96'(1));
    dat = s_dat_o;
    s_cyc_i = 1'b0; s_stb_i = 1'b0;
    cyc1();
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!wbuf_empty && n < 500) begin cyc1(); n++; end
    chk(tag, 96'(wbuf_empty), 96'(1));
  endtask

  initial begin
    int l;
    int base;
    int l5;
    logic [DW-1:0] rd;
    logic [AW+SW+DW-1:0] exp_q [$];
    logic [AW+SW+DW-1:0] e;

    // Reset state
    cyc1(); cyc1();
    chk("rst_s_ack", 96'(s_ack_o), 96'(0));
    chk("rst_m_cyc", 96'(m_cyc_o), 96'(0));
    chk("rst_m_stb", 96'(m_stb_o), 96'(0));
    chk("rst_m_adr", 96'(m_adr_o), 96'(0));
    chk("rst_s_dat", 96'(s_dat_o), 96'(0));
    chk("rst_empty", 96'(wbuf_empty), 96'(1));
    wb_rst_i = 1'b0;
    cyc1();

    // 1: single write, 1-cycle ack, forwarded next cycle
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = 1'b1;
    s_adr_i = 32'h100; s_dat_i = 32'hDEADBEEF; s_sel_i = 4'hF;
    cyc1();
    chk("t1_ack_1cyc", 96'(s_ack_o), 96'(1));
    chk("t1_not_empty", 96'(wbuf_empty), 96'(0));
    up_acks++;
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    cyc1();
    chk("t1_ack_pulse", 96'(s_ack_o), 96'(0));
    chk("t1_m_stb", 96'(m_stb_o), 96'(1));
    chk("t1_m_cyc", 96'(m_cyc_o), 96'(1));
    chk("t1_m_we", 96'(m_we_o), 96'(1));
    chk("t1_m_adr", 96'(m_adr_o), 96'(32'h100));
    chk("t1_m_dat", 96'(m_dat_o), 96'(32'hDEADBEEF));
    chk("t1_m_sel", 96'(m_sel_o), 96'(4'hF));
    wait_empty("t1_drain");
    chk("t1_log", 96'(wr_log.size()), 96'(1));
    chk("t1_m_stb_low", 96'(m_stb_o), 96'(0));

    // 2: five back-to-back writes, fifth stalls on a full queue
    base = wr_log.size();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      e = {32'h2000 + 32'(i * 4), 4'hF, 32'hA0A0_0000 + 32'(i)};
      exp_q.push_back(e);
      wb_write(e[67:36], e[31:0], e[35:32], l);
      if (i < 4) chk($sformatf("t2_lat_w%0d", i), 96'(l), 96'(1));
      else l5 = l;
    end
    chk("t2_w5_stalled", 96'(l5 > 1), 96'(1));
    chk("t2_w5_after_first_dn_ack", 96'(wr_log.size() - base), 96'(1));
    wait_empty("t2_drain");
    chk("t2_count", 96'(wr_log.size() - base), 96'(5));
    for (int i = 0; i < 5; i++)
      chk($sformatf("t2_order_%0d", i), 96'(wr_log[base + i]), 96'(exp_q[i]));

    // 3: read-after-write sees the posted data, never overtakes it
    wb_write(32'h200, 32'h12345678, 4'hF, l);
    wb_read(32'h200, rd);
    chk("t3_rd_data", 96'(rd), 96'(32'h12345678));
    chk("t3_no_overtake", 96'(order_viol), 96'(0));

    // 4: partial byte selects forwarded, reads use all-ones selects
    wb_write(32'h300, 32'hAABBCCDD, 4'h3, l);
    l = 0;
    while (!m_stb_o && l < 50) begin cyc1(); l++; end
    chk("t4_wr_sel", 96'(m_sel_o), 96'(4'h3));
    chk("t4_wr_adr", 96'(m_adr_o), 96'(32'h300));
    wait_empty("t4_drain");
    wb_read(32'h300, rd);
    chk("t4_rd_data", 96'(rd), 96'(32'h0000CCDD));
    chk("t4_rd_sel", 96'(last_rd_sel), 96'(4'hF));
    chk("t4_rd_adr", 96'(last_rd_adr), 96'(32'h300));

    // 5: async reset with three writes queued and a write in flight
    for (int i = 0; i < 3; i++) wb_write(32'h400 + 32'(i * 4), 32'h5500 + 32'(i), 4'hF, l);
    chk("t5_pre_stb", 96'(m_stb_o), 96'(1));
    chk("t5_pre_empty", 96'(wbuf_empty), 96'(0));
    #2 wb_rst_i = 1'b1;
    #1;
    chk("t5_stb_drop", 96'(m_stb_o), 96'(0));
    chk("t5_cyc_drop", 96'(m_cyc_o), 96'(0));
    chk("t5_empty", 96'(wbuf_empty), 96'(1));
    up_acks = dn_acks;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    base = stb_cycles;
    repeat (30) cyc1();
    chk("t5_no_traffic", 96'(stb_cycles - base), 96'(0));
    chk("t5_still_empty", 96'(wbuf_empty), 96'(1));

    // 6: 20 streaming writes with a fast downstream, scoreboarded
    lat = 3;
    base = wr_log.size();
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      e = {32'h1000 + 32'(i * 4), 4'hF, 32'($urandom)};
      exp_q.push_back(e);
      wb_write(e[67:36], e[31:0], e[35:32], l);
    end
    wait_empty("t6_drain");
    chk("t6_count", 96'(wr_log.size() - base), 96'(20));
    for (int i = 0; i < 20; i++)
      chk($sformatf("t6_entry_%0d", i), 96'(wr_log[base + i]), 96'(exp_q[i]));
    chk("t6_no_overtake", 96'(order_viol), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
